i2s_capture: RTL and testbench

Parametrised I2S receiver for the ADC front end: deserialises both left and right slots from the `sd` line, tags each sample with its channel and buffers the samples in a small FIFO. Samples leave through a valid/ready handshake to the downstream mux. Compared with the single-channel, single-word receiver, this block adds:
- configurable sample and output widths;
- stereo capture;
- FIFO depth;
- overflow and framing-error reporting.

---
 rtl/i2s_capture.sv | 96 +++++++++
 tb/tb_i2s_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_capture.sv
// i2s_capture: stereo I2S receiver; channel-tagged samples buffered in a FWFT FIFO.
// Define I2S_CAPTURE_SIGN_EXT_EN for right-justified, sign-extended output words.
module i2s_capture #(
  parameter int SAMPLE_W   = 24,
  parameter int SLOT_W     = 32,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sck,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          ws,
  input  logic                          sd,
  input  logic                          rdy_in,
  output logic                          vld_out,
  output logic [OUT_W-1:0]              data_out,
  output logic                          ch_out,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SLOT_W + 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_W);
  typedef enum logic [1:0] {IDLE, SYNC, CAP} state_t;
  state_t state_q, state_d;
  logic ws_q, ch_q, ch_d, ovf_q, ovf_d, ferr_q, ferr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] sh_q, sh_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] lvl_q, lvl_d;
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic mch_q [FIFO_DEPTH];
  logic [OUT_W-1:0] word;
  logic ws_edge, slot_go, push, pop, full, wr_en;
`ifdef I2S_CAPTURE_SIGN_EXT_EN
  assign word = OUT_W'(signed'(sh_q));
`else
  assign word = OUT_W'(sh_q) << (OUT_W - SAMPLE_W);
`endif
  assign vld_out   = lvl_q != '0;
  assign data_out  = vld_out ? mem_q[rd_q] : '0;
  assign ch_out    = vld_out & mch_q[rd_q];
  assign level     = lvl_q;
  assign overflow  = ovf_q;
  assign frame_err = ferr_q;
  // cnt counts captured bits; LAST means word complete, LAST+1 means already pushed
  always_comb begin
    ws_edge = ws != ws_q;
    slot_go = ws_edge && state_q != IDLE;
    push    = state_q == CAP && cnt_q == LAST;
    pop     = vld_out && rdy_in;
    full    = lvl_q == (AW+1)'(FIFO_DEPTH);
    wr_en   = push && (!full || pop);
    state_d = (state_q == IDLE && start) ? SYNC : (state_q == SYNC && ws_edge) ? CAP : state_q;
    cnt_d   = slot_go ? '0 : (state_q == CAP && cnt_q <= LAST) ? cnt_q + 1'b1 : cnt_q;
    sh_d    = (state_q == CAP && !ws_edge && cnt_q < LAST) ? {sh_q[SAMPLE_W-2:0], sd} : sh_q;
    ch_d    = slot_go ? ws : ch_q;
    ferr_d  = ferr_q | (state_q == CAP && ws_edge && cnt_q < LAST);
    ovf_d   = ovf_q | (push && full && !pop);
    wr_d    = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    lvl_d   = lvl_q + (AW+1)'(wr_en) - (AW+1)'(pop);
  end
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ws_q    <= 1'b0;
      ch_q    <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end
  always_ff @(posedge sck) begin
    if (wr_en) begin
      mem_q[wr_q] <= word;
      mch_q[wr_q] <= ch_q;
    end
  end
endmodule

// File: tb/tb_i2s_capture.sv
// tb_i2s_capture: directed checks of capture format, latency, FIFO full/overflow, framing and reset.
module tb_i2s_capture;
  localparam int SW = 24, SL = 32, OW = 32;
  logic sck = 0, rst = 1, start = 0, ws = 1, sd = 0, rdy_in = 0;
  logic vld_out, ch_out, overflow, frame_err;
  logic [OW-1:0] data_out;
  logic [2:0] level;
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [OW-1:0] got_d[$], ed[$];
  logic got_c[$], ec[$];
  int rise_q[$], edge_q[$];
  logic vld_p = 0;

  i2s_capture dut (
    .sck(sck), .rst(rst), .start(start), .ws(ws), .sd(sd), .rdy_in(rdy_in),
    .vld_out(vld_out), .data_out(data_out), .ch_out(ch_out), .level(level),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 sck = ~sck;
  always @(posedge sck) cyc <= cyc + 1;
  always @(negedge sck) begin
    if (vld_out && !vld_p) rise_q.push_back(cyc);
    vld_p = vld_out;
    if (vld_out && rdy_in) begin
      got_d.push_back(data_out);
      got_c.push_back(ch_out);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] fmt(input logic [SW-1:0] s);
`ifdef I2S_CAPTURE_SIGN_EXT_EN
    return {{(OW-SW){s[SW-1]}}, s};
`else
    return {s, {(OW-SW){1'b0}}};
`endif
  endfunction

  task automatic tick();
    @(posedge sck);
    #2;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      sd = 0;
    end
  endtask

  // one slot: toggle ws, then MSB-first bits; optional start pulse and a rdy pulse on the push edge
  task automatic slot(input logic [SW-1:0] w, input int len = SL, input int st = -1, input bit pr = 0);
    for (int k = 0; k < len; k++) begin
      tick();
      if (k == 0) begin
        ws = ~ws;
        edge_q.push_back(cyc + 1);
      end
      sd = (k >= 1 && k <= SW) ? w[SW-k] : 1'b0;
      start = (k == st);
      if (pr) rdy_in = (k == SW + 1);
    end
  endtask

  task automatic clear_q();
    got_d.delete(); got_c.delete(); ed.delete(); ec.delete();
    rise_q.delete(); edge_q.delete();
  endtask

  task automatic do_reset();
    rst = 1; ws = 1; start = 0; sd = 0;
    tick();
    tick();
    rst = 0;
    clear_q();
  endtask

  task automatic arm();
    tick();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic want(input logic [SW-1:0] s, input logic c);
    ed.push_back(fmt(s));
    ec.push_back(c);
  endtask

  task automatic check_stream(input string tag);
    check($sformatf("%s_count", tag), 64'(got_d.size()), 64'(ed.size()));
    foreach (ed[i]) begin
      check($sformatf("%s_data%0d", tag, i), (i < got_d.size()) ? 64'(got_d[i]) : 'x, 64'(ed[i]));
      check($sformatf("%s_ch%0d", tag, i), (i < got_c.size()) ? 64'(got_c[i]) : 'x, 64'(ec[i]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vld"}, 64'(vld_out), 0);
    check({tag, "_data"}, 64'(data_out), 0);
    check({tag, "_ch"}, 64'(ch_out), 0);
    check({tag, "_level"}, 64'(level), 0);
    check({tag, "_ovf"}, 64'(overflow), 0);
    check({tag, "_ferr"}, 64'(frame_err), 0);
  endtask

  initial begin
    // basic stereo capture, format and latency
    rst = 1;
    tick();
    check_reset_outputs("por");
    do_reset();
    rdy_in = 1;
    arm();
    slot(24'hA5A5A5);
    slot(24'h800001);
    idle(4);
    check("t1_count", 64'(got_d.size()), 2);
`ifdef I2S_CAPTURE_SIGN_EXT_EN
    check("t1_left", (got_d.size() > 0) ? 64'(got_d[0]) : 'x, 64'h0000_0000_FFA5_A5A5);
    check("t1_right", (got_d.size() > 1) ? 64'(got_d[1]) : 'x, 64'h0000_0000_FF80_0001);
`else
    check("t1_left", (got_d.size() > 0) ? 64'(got_d[0]) : 'x, 64'h0000_0000_A5A5_A500);
    check("t1_right", (got_d.size() > 1) ? 64'(got_d[1]) : 'x, 64'h0000_0000_8000_0100);
`endif
    check("t1_ch_left", (got_c.size() > 0) ? 64'(got_c[0]) : 'x, 0);
    check("t1_ch_right", (got_c.size() > 1) ? 64'(got_c[1]) : 'x, 1);
    check("t1_rises", 64'(rise_q.size()), 2);
    check("t1_lat0", (rise_q.size() > 0) ? 64'(rise_q[0] - edge_q[0]) : 'x, 25);
    check("t1_lat1", (rise_q.size() > 1) ? 64'(rise_q[1] - edge_q[1]) : 'x, 25);
    check("t1_level", 64'(level), 0);
    check("t1_ovf", 64'(overflow), 0);
    check("t1_ferr", 64'(frame_err), 0);

    // overflow: six words with rdy low, then a push accepted alongside a pop while full
    do_reset();
    rdy_in = 0;
    arm();
    slot(24'h111111); slot(24'h222222); slot(24'h333333);
    slot(24'h444444); slot(24'h555555); slot(24'h666666);
    check("t3_level_full", 64'(level), 4);
    check("t3_ovf", 64'(overflow), 1);
    slot(24'h777777, SL, -1, 1);
    check("t3_level_after_swap", 64'(level), 4);
    rdy_in = 1;
    idle(8);
    want(24'h111111, 0); want(24'h222222, 1); want(24'h333333, 0);
    want(24'h444444, 1); want(24'h777777, 0);
    check_stream("t3");
    check("t3_level_drained", 64'(level), 0);

    // no capture without start; start mid-slot waits for the next ws edge
    do_reset();
    rdy_in = 1;
    slot(24'hABCDEF); slot(24'h123456); slot(24'hABCDEF); slot(24'h123456);
    check("t4_no_start_count", 64'(got_d.size()), 0);
    check("t4_no_start_level", 64'(level), 0);
    slot(24'hDEAD00, SL, 10);
    slot(24'h5A5A5A);
    slot(24'hC3C3C3);
    idle(4);
    want(24'h5A5A5A, 1); want(24'hC3C3C3, 0);
    check_stream("t4");

    // short slot raises frame_err and is dropped
    do_reset();
    rdy_in = 1;
    arm();
    slot(24'h0F0F0F);
    check("t5_ferr_clean", 64'(frame_err), 0);
    slot(24'hFFFFFF, 10);
    slot(24'h3C3C3C);
    slot(24'hE00007);
    idle(4);
    check("t5_ferr", 64'(frame_err), 1);
    check("t5_ovf", 64'(overflow), 0);
    want(24'h0F0F0F, 0); want(24'h3C3C3C, 0); want(24'hE00007, 1);
    check_stream("t5");

    // async reset mid-slot with two buffered words
    do_reset();
    rdy_in = 0;
    arm();
    slot(24'h246802);
    slot(24'h13579B);
    slot(24'hFFFFFF, 12);
    check("t6_level_pre", 64'(level), 2);
    check("t6_vld_pre", 64'(vld_out), 1);
    rst = 1;
    ws = 1;
    #1;
    check_reset_outputs("t6_rst");
    tick();
    rst = 0;
    clear_q();
    slot(24'h999999); slot(24'h888888);
    check("t6_no_rearm_level", 64'(level), 0);
    arm();
    slot(24'h4B4B4B);
    slot(24'hB4B4B4);
    check("t6_level_rearm", 64'(level), 2);
    rdy_in = 1;
    idle(4);
    want(24'h4B4B4B, 0); want(24'hB4B4B4, 1);
    check_stream("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
